// File: rtl/work_frame_sender_pkg.sv
// Shared constants, TX state encoding and frame packing for the work/nonce link.
package work_frame_sender_pkg;

  localparam int unsigned FRAME_BYTES = 64;
  localparam int unsigned NONCE_BYTES = 4;
  localparam int unsigned MIDSTATE_W  = 256;
  localparam int unsigned DATA2_W     = 96;
  localparam int unsigned PAD_BYTES   = 20;
  localparam int unsigned FRAME_W     = FRAME_BYTES * 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

  // Frame image sent MSB first: midstate, zero pad, data2.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [MIDSTATE_W-1:0] ms,
    input logic [DATA2_W-1:0]    d2
  );
    return {ms, {(PAD_BYTES * 8){1'b0}}, d2};
  endfunction

endpackage

// File: rtl/uart.sv
// 8N1 uart core, 16x oversampled, no reset. State is held so that an
// all-zero power-up value means "idle, line high".
module uart #(
  parameter int CLOCK        = 25000000,
  parameter int BAUD         = 57600,
  parameter int SAMPLE_POINT = 8
) (
  input  logic       clk,
  input  logic       rx,
  output logic       tx,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic [7:0] rx_byte,
  output logic       rx_data_ready
);

  localparam int unsigned DIV_RAW = CLOCK / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0]  SP      = 4'(SAMPLE_POINT);

  logic [DIV_W-1:0] tick_cnt_q;
  logic             tick;

  logic       tx_active_q;
  logic       tx_line_n_q;
  logic [8:0] tx_shift_q;
  logic [3:0] tx_bit_q;
  logic [3:0] tx_os_q;

  logic       rx_meta_n_q;
  logic       rx_sync_n_q;
  logic       rx_s;
  logic       rx_active_q;
  logic [3:0] rx_os_q;
  logic [3:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  logic [7:0] rx_byte_q;
  logic       rx_ready_q;

  assign tick = (tick_cnt_q == DIV_W'(DIV - 1));

  // Free-running oversample tick divider.
  always_ff @(posedge clk) begin
    tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit; 16 ticks per bit.
  always_ff @(posedge clk) begin
    if (!tx_active_q) begin
      if (tx_start) begin
        tx_active_q <= 1'b1;
        tx_line_n_q <= 1'b1;
        tx_shift_q  <= {1'b1, tx_byte};
        tx_bit_q    <= '0;
        tx_os_q     <= '0;
      end
    end else if (tick) begin
      tx_os_q <= tx_os_q + 4'd1;
      if (tx_os_q == 4'd15) begin
        if (tx_bit_q == 4'd9) begin
          tx_active_q <= 1'b0;
          tx_line_n_q <= 1'b0;
        end else begin
          tx_line_n_q <= ~tx_shift_q[0];
          tx_shift_q  <= {1'b0, tx_shift_q[8:1]};
          tx_bit_q    <= tx_bit_q + 4'd1;
        end
      end
    end
  end

  assign tx      = ~tx_line_n_q;
  assign tx_busy = tx_active_q;

  // Two-flop synchroniser on the incoming line (stored inverted).
  always_ff @(posedge clk) begin
    rx_meta_n_q <= ~rx;
    rx_sync_n_q <= rx_meta_n_q;
  end

  assign rx_s = ~rx_sync_n_q;

  // Receiver: qualify start bit at the sample point, then sample each bit there.
  always_ff @(posedge clk) begin
    rx_ready_q <= 1'b0;
    if (tick) begin
      if (!rx_active_q) begin
        if (!rx_s) begin
          rx_active_q <= 1'b1;
          rx_os_q     <= '0;
          rx_bit_q    <= '0;
        end
      end else begin
        rx_os_q <= rx_os_q + 4'd1;
        if (rx_os_q == SP) begin
          if (rx_bit_q == 4'd0) begin
            if (rx_s) rx_active_q <= 1'b0;
          end else if (rx_bit_q <= 4'd8) begin
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
          end else begin
            rx_active_q <= 1'b0;
            if (rx_s) begin
              rx_byte_q  <= rx_shift_q;
              rx_ready_q <= 1'b1;
            end
          end
        end
        if (rx_os_q == 4'd15) rx_bit_q <= rx_bit_q + 4'd1;
      end
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_data_ready = rx_ready_q;

endmodule

// File: rtl/work_frame_sender_nonce_assembler.sv
// Collects 4 received bytes MSB first into a nonce word; a partial word is
// dropped after RX_TIMEOUT idle cycles.
module work_frame_sender_nonce_assembler
  import work_frame_sender_pkg::*;
#(
  parameter int RX_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] nonce_o,
  output logic        nonce_valid_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned TMO_W = (RX_TIMEOUT > 2) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RX_TIMEOUT - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(NONCE_BYTES - 1);

  logic [23:0]      sr_q, sr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      nonce_q, nonce_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Next-state: a received byte always takes priority over the timeout.
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    nonce_d   = nonce_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    tmo_d     = '0;
    if (byte_valid_i) begin
      sr_d  = {sr_q[15:0], byte_i};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == LAST_BYTE) begin
        nonce_d = {sr_q, byte_i};
        valid_d = 1'b1;
      end
    end else if (cnt_q != 2'd0) begin
      if (tmo_q == TMO_LAST) begin
        cnt_d     = '0;
        timeout_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      nonce_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      nonce_q   <= nonce_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      tmo_q     <= tmo_d;
    end
  end

  assign nonce_o       = nonce_q;
  assign nonce_valid_o = valid_q;
  assign busy_o        = (cnt_q != 2'd0);
  assign timeout_o     = timeout_q;

endmodule

// File: rtl/work_frame_sender.sv
// Host side of the miner serial link: sends 64-byte work frames and
// collects 4-byte nonce replies over one shared uart.
module work_frame_sender
  import work_frame_sender_pkg::*;
#(
  parameter int CLOCK        = 25000000,
  parameter int BAUD         = 57600,
  parameter int SAMPLE_POINT = 8,
  parameter int RX_TIMEOUT   = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  tx,
  input  logic                  work_valid,
  output logic                  work_ready,
  input  logic [MIDSTATE_W-1:0] midstate,
  input  logic [DATA2_W-1:0]    data2,
  output logic [31:0]           nonce,
  output logic                  nonce_valid,
  output logic                  tx_busy,
  output logic                  rx_busy,
  output logic                  rx_timeout
);

  localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

  tx_state_e          state_q;
  logic [FRAME_W-1:0] buf_q;
  logic [5:0]         byte_cnt_q;
  logic               tx_start_q;
  logic [7:0]         tx_byte_q;

  logic       uart_tx_busy;
  logic [7:0] uart_rx_byte;
  logic       uart_rx_ready;

  uart #(
    .CLOCK        (CLOCK),
    .BAUD         (BAUD),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_uart (
    .clk           (clk),
    .rx            (rx),
    .tx            (tx),
    .tx_start      (tx_start_q),
    .tx_byte       (tx_byte_q),
    .tx_busy       (uart_tx_busy),
    .rx_byte       (uart_rx_byte),
    .rx_data_ready (uart_rx_ready)
  );

  // TX FSM: latch frame, then hand one byte at a time to the uart.
  // LOAD waits for the uart to go idle, so a byte still on the wire after a
  // mid-frame reset finishes before the next frame starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      byte_cnt_q <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      buf_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        TX_IDLE: begin
          if (work_valid) begin
            buf_q   <= pack_frame(midstate, data2);
            state_q <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          if (!uart_tx_busy) begin
            tx_byte_q  <= buf_q[FRAME_W-1 -: 8];
            tx_start_q <= 1'b1;
            buf_q      <= {buf_q[FRAME_W-9:0], 8'h00};
            state_q    <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (uart_tx_busy) state_q <= TX_WAIT_LO;
        end
        TX_WAIT_LO: begin
          if (!uart_tx_busy) begin
            byte_cnt_q <= byte_cnt_q + 6'd1;
            state_q    <= (byte_cnt_q == LAST_IDX) ? TX_IDLE : TX_LOAD;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_busy    = (state_q != TX_IDLE);
  assign work_ready = (state_q == TX_IDLE);

  work_frame_sender_nonce_assembler #(
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_nonce (
    .clk           (clk),
    .reset         (reset),
    .byte_valid_i  (uart_rx_ready),
    .byte_i        (uart_rx_byte),
    .nonce_o       (nonce),
    .nonce_valid_o (nonce_valid),
    .busy_o        (rx_busy),
    .timeout_o     (rx_timeout)
  );

endmodule

// File: tb/tb_work_frame_sender.sv
// Directed bench for work_frame_sender: 16 clocks per serial bit.
module tb_work_frame_sender;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx;
  logic         tx;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] midstate;
  logic [95:0]  data2;
  logic [31:0]  nonce;
  logic         nonce_valid;
  logic         tx_busy;
  logic         rx_busy;
  logic         rx_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  txq[$];
  logic [31:0] nq[$];
  int frame_err = 0;
  int nv_wide   = 0;
  int to_pulses = 0;
  logic prev_nv = 1'b0;

  localparam logic [255:0] MS_A = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [95:0]  D2_A = 96'hA0A1A2A3A4A5A6A7A8A9AAAB;
  localparam logic [255:0] MS_B = {8{32'hC0FFEE11}};
  localparam logic [95:0]  D2_B = 96'h0123456789ABCDEF55AA33CC;
  localparam logic [255:0] MS_C = {8{32'h5A5A0F0F}};
  localparam logic [95:0]  D2_C = {3{32'hF00DBEEF}};
  localparam logic [255:0] MS_D = {8{32'h89ABCDEF}};
  localparam logic [95:0]  D2_D = {3{32'h76543210}};
  localparam logic [255:0] MS_E = {16{16'h1357}};
  localparam logic [95:0]  D2_E = {6{16'h2468}};

  always #5 clk = ~clk;

  work_frame_sender #(
    .CLOCK        (16),
    .BAUD         (1),
    .SAMPLE_POINT (8),
    .RX_TIMEOUT   (1000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .tx          (tx),
    .work_valid  (work_valid),
    .work_ready  (work_ready),
    .midstate    (midstate),
    .data2       (data2),
    .nonce       (nonce),
    .nonce_valid (nonce_valid),
    .tx_busy     (tx_busy),
    .rx_busy     (rx_busy),
    .rx_timeout  (rx_timeout)
  );

  // Serial decoder on tx: 8N1, LSB first, sampled mid-bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = tx;
      end
      repeat (16) @(negedge clk);
      if (tx !== 1'b1) frame_err++;
      txq.push_back(b);
    end
  end

  // Nonce / timeout pulse recorder.
  always @(negedge clk) begin
    if (nonce_valid === 1'b1) begin
      nq.push_back(nonce);
      if (prev_nv) nv_wide++;
    end
    prev_nv = (nonce_valid === 1'b1);
    if (rx_timeout === 1'b1) to_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [255:0] ms, input logic [95:0] d2, input int idx);
    logic [511:0] f;
    f = {ms, 160'h0, d2};
    return f[511 - 8 * idx -: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
    repeat (18) @(negedge clk);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int c = 0;
    while (txq.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(txq.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (tx_busy && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(tx_busy), 32'd0);
    chk({tag, "_ready"}, 32'(work_ready), 32'd1);
  endtask

  task automatic chk_frame(input string tag, input int base, input logic [255:0] ms, input logic [95:0] d2);
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(txq[base + i]), 32'(exp_byte(ms, d2, i)));
  endtask

  initial begin
    reset      = 1'b1;
    rx         = 1'b1;
    work_valid = 1'b0;
    midstate   = '0;
    data2      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_work_ready", 32'(work_ready), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_nonce", nonce, 32'd0);
    chk("rst_nonce_valid", 32'(nonce_valid), 32'd0);
    chk("rst_rx_busy", 32'(rx_busy), 32'd0);
    chk("rst_rx_timeout", 32'(rx_timeout), 32'd0);
    chk("rst_tx_line", 32'(tx), 32'd1);

    // Frame A with two nonces arriving concurrently.
    midstate = MS_A;
    data2 = D2_A;
    work_valid = 1'b1;
    @(negedge clk);
    work_valid = 1'b0;
    chk("a_tx_busy", 32'(tx_busy), 32'd1);
    chk("a_work_ready", 32'(work_ready), 32'd0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    chk("dup_nonce_cnt", 32'(nq.size()), 32'd2);
    chk("dup_nonce0", nq[0], 32'h01020304);
    chk("dup_nonce1", nq[1], 32'h05060708);
    chk("a_mid_busy", 32'(tx_busy), 32'd1);
    wait_bytes("a_bytes", 64, 12000);
    for (int i = 0; i < 64; i++)
      chk($sformatf("a_b%0d", i), 32'(txq[i]),
          (i < 32) ? 32'(i) : (i < 52) ? 32'd0 : 32'(8'hA0 + i - 52));
    wait_idle("a_idle");

    // Back-pressure: work_valid held across frame B, C value presented meanwhile.
    txq.delete();
    midstate = MS_B;
    data2 = D2_B;
    work_valid = 1'b1;
    @(negedge clk);
    midstate = MS_C;
    data2 = D2_C;
    chk("b_tx_busy", 32'(tx_busy), 32'd1);
    repeat (3000) @(negedge clk);
    chk("b_mid_ready", 32'(work_ready), 32'd0);
    wait_bytes("b_bytes", 64, 12000);
    begin
      int c = 0;
      while (tx_busy && c < 200) begin
        @(negedge clk);
        c++;
      end
    end
    chk("b_end_ready", 32'(work_ready), 32'd1);
    @(negedge clk);
    chk("c_tx_busy", 32'(tx_busy), 32'd1);
    work_valid = 1'b0;
    wait_bytes("bc_bytes", 128, 12000);
    wait_idle("c_idle");
    repeat (400) @(negedge clk);
    chk("bc_total", 32'(txq.size()), 32'd128);
    chk_frame("b", 0, MS_B, D2_B);
    chk_frame("c", 64, MS_C, D2_C);

    // Nonce DEADBEEF.
    nq.delete();
    send_byte(8'hDE);
    chk("dead_busy1", 32'(rx_busy), 32'd1);
    send_byte(8'hAD);
    send_byte(8'hBE);
    chk("dead_busy3", 32'(rx_busy), 32'd1);
    send_byte(8'hEF);
    chk("dead_busy4", 32'(rx_busy), 32'd0);
    chk("dead_nonce", nonce, 32'hDEADBEEF);
    chk("dead_cnt", 32'(nq.size()), 32'd1);
    chk("dead_q", nq[0], 32'hDEADBEEF);

    // Timeout of a partial nonce.
    nq.delete();
    to_pulses = 0;
    send_byte(8'h12);
    send_byte(8'h34);
    chk("to_busy", 32'(rx_busy), 32'd1);
    repeat (900) @(negedge clk);
    chk("to_early", 32'(to_pulses), 32'd0);
    chk("to_busy_early", 32'(rx_busy), 32'd1);
    begin
      int c = 0;
      while (to_pulses == 0 && c < 300) begin
        @(negedge clk);
        c++;
      end
    end
    repeat (5) @(negedge clk);
    chk("to_pulses", 32'(to_pulses), 32'd1);
    chk("to_busy_after", 32'(rx_busy), 32'd0);
    chk("to_nonce_kept", nonce, 32'hDEADBEEF);
    chk("to_no_valid", 32'(nq.size()), 32'd0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("to_next_nonce", nonce, 32'h11223344);
    chk("to_next_cnt", 32'(nq.size()), 32'd1);

    // Reset during byte 10 of frame D, then frame E.
    txq.delete();
    midstate = MS_D;
    data2 = D2_D;
    work_valid = 1'b1;
    @(negedge clk);
    work_valid = 1'b0;
    wait_bytes("d_ten", 10, 3000);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(tx_busy), 32'd0);
    chk("rst_mid_ready", 32'(work_ready), 32'd1);
    chk("rst_mid_nonce", nonce, 32'd0);
    chk("rst_mid_rx_busy", 32'(rx_busy), 32'd0);
    midstate = MS_E;
    data2 = D2_E;
    work_valid = 1'b1;
    @(negedge clk);
    work_valid = 1'b0;
    wait_bytes("de_bytes", 75, 13000);
    wait_idle("e_idle");
    for (int i = 0; i < 11; i++)
      chk($sformatf("d_b%0d", i), 32'(txq[i]), 32'(exp_byte(MS_D, D2_D, i)));
    chk_frame("e", 11, MS_E, D2_E);

    chk("tx_framing", 32'(frame_err), 32'd0);
    chk("nonce_valid_width", 32'(nv_wide), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
